// File: rtl/axi4_lite_remap_pkg.sv
// Shared definitions for the AXI4-Lite window remapper: response codes,
// channel field widths and the write/read FSM state encodings.
package axi4_lite_remap_pkg;

  localparam int unsigned PROT_W = 3;
  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_ISSUE = 2'd1,
    W_RESP  = 2'd2,
    W_DONE  = 2'd3
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_RESP  = 2'd2,
    R_DONE  = 2'd3
  } r_state_t;

endpackage

// File: rtl/axi4_lite_window_decode.sv
// Combinational window decoder: compares the address tag against each
// window's local base and produces the translated remote address.
// Ports:
//   i_addr  in   AXI_ADDR_WIDTH  incoming address
//   o_hit   out  1               some window matched
//   o_addr  out  AXI_ADDR_WIDTH  translated address (0 on miss)
module axi4_lite_window_decode #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned NUM_WINDOWS    = 2,
  parameter int unsigned WINDOW_BITS    = 16,
  parameter logic [NUM_WINDOWS*AXI_ADDR_WIDTH-1:0] LOCAL_BASE  = {32'h5000_0000, 32'h4000_0000},
  parameter logic [NUM_WINDOWS*AXI_ADDR_WIDTH-1:0] REMOTE_BASE = {32'h8000_0000, 32'h0000_0000}
) (
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
  output logic                      o_hit,
  output logic [AXI_ADDR_WIDTH-1:0] o_addr
);

  localparam int unsigned TAG_W = AXI_ADDR_WIDTH - WINDOW_BITS;

  // Ascending scan; first match locks in so the lowest index wins on overlap.
  always_comb begin
    o_hit  = 1'b0;
    o_addr = '0;
    for (int unsigned i = 0; i < NUM_WINDOWS; i++) begin
      if (!o_hit &&
          (i_addr[AXI_ADDR_WIDTH-1:WINDOW_BITS] ==
           LOCAL_BASE[i*AXI_ADDR_WIDTH+WINDOW_BITS +: TAG_W])) begin
        o_hit  = 1'b1;
        o_addr = {REMOTE_BASE[i*AXI_ADDR_WIDTH+WINDOW_BITS +: TAG_W],
                  i_addr[WINDOW_BITS-1:0]};
      end
    end
  end

endmodule

// File: rtl/axi4_lite_window_remapper.sv
// AXI4-Lite address window remapper. Accepts one write and one read
// transaction at a time on the slave port, translates hitting addresses to
// the remote window and replays them on the master port; misses are answered
// locally with DECERR. All outputs are registered.
// Ports:
//   clk, resetn               clock, async active-low reset
//   S_AXI_AW*/W*/B*/AR*/R*    slave (upstream) AXI4-Lite port
//   M_AXI_AW*/W*/B*/AR*/R*    master (downstream) AXI4-Lite port
module axi4_lite_window_remapper
  import axi4_lite_remap_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned NUM_WINDOWS    = 2,
  parameter int unsigned WINDOW_BITS    = 16,
  parameter logic [NUM_WINDOWS*AXI_ADDR_WIDTH-1:0] LOCAL_BASE  = {32'h5000_0000, 32'h4000_0000},
  parameter logic [NUM_WINDOWS*AXI_ADDR_WIDTH-1:0] REMOTE_BASE = {32'h8000_0000, 32'h0000_0000}
) (
  input  logic                        clk,
  input  logic                        resetn,
  // slave write address / data / response
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                  S_AXI_AWPROT,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  // slave read address / data
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                  S_AXI_ARPROT,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  // master write address / data / response
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  // master read address / data
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  localparam int unsigned AW     = AXI_ADDR_WIDTH;
  localparam int unsigned DW     = AXI_DATA_WIDTH;
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  // ---------------------------------------------------------------- decoders
  logic          w_aw_hit, w_ar_hit;
  logic [AW-1:0] w_aw_xaddr, w_ar_xaddr;

  axi4_lite_window_decode #(
    .AXI_ADDR_WIDTH (AW), .NUM_WINDOWS (NUM_WINDOWS), .WINDOW_BITS (WINDOW_BITS),
    .LOCAL_BASE (LOCAL_BASE), .REMOTE_BASE (REMOTE_BASE)
  ) u_aw_decode (
    .i_addr (S_AXI_AWADDR), .o_hit (w_aw_hit), .o_addr (w_aw_xaddr)
  );

  axi4_lite_window_decode #(
    .AXI_ADDR_WIDTH (AW), .NUM_WINDOWS (NUM_WINDOWS), .WINDOW_BITS (WINDOW_BITS),
    .LOCAL_BASE (LOCAL_BASE), .REMOTE_BASE (REMOTE_BASE)
  ) u_ar_decode (
    .i_addr (S_AXI_ARADDR), .o_hit (w_ar_hit), .o_addr (w_ar_xaddr)
  );

  // -------------------------------------------------------------- write path
  w_state_t          r_wstate, w_wstate_n;
  logic              r_aw_got, w_aw_got_n, r_w_got, w_w_got_n, r_aw_hit, w_aw_hit_n;
  logic              r_s_awready, w_s_awready_n, r_s_wready, w_s_wready_n;
  logic              r_s_bvalid, w_s_bvalid_n;
  logic [RESP_W-1:0] r_s_bresp, w_s_bresp_n;
  logic              r_m_awvalid, w_m_awvalid_n, r_m_wvalid, w_m_wvalid_n;
  logic              r_m_bready, w_m_bready_n;
  logic [AW-1:0]     r_m_awaddr, w_m_awaddr_n;
  logic [PROT_W-1:0] r_m_awprot, w_m_awprot_n;
  logic [DW-1:0]     r_m_wdata, w_m_wdata_n;
  logic [STRB_W-1:0] r_m_wstrb, w_m_wstrb_n;
  logic              w_aw_hs, w_w_hs;

  assign w_aw_hs = S_AXI_AWVALID && r_s_awready;
  assign w_w_hs  = S_AXI_WVALID && r_s_wready;

  // Write next-state and next-output logic. AW is decoded as it is captured,
  // so the master-side address/data are already loaded when both halves land.
  always_comb begin
    w_wstate_n    = r_wstate;
    w_aw_got_n    = r_aw_got;
    w_w_got_n     = r_w_got;
    w_aw_hit_n    = r_aw_hit;
    w_s_bvalid_n  = r_s_bvalid;
    w_s_bresp_n   = r_s_bresp;
    w_m_awvalid_n = r_m_awvalid;
    w_m_wvalid_n  = r_m_wvalid;
    w_m_bready_n  = r_m_bready;
    w_m_awaddr_n  = r_m_awaddr;
    w_m_awprot_n  = r_m_awprot;
    w_m_wdata_n   = r_m_wdata;
    w_m_wstrb_n   = r_m_wstrb;

    unique case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs) begin
          w_aw_got_n   = 1'b1;
          w_aw_hit_n   = w_aw_hit;
          w_m_awaddr_n = w_aw_xaddr;
          w_m_awprot_n = S_AXI_AWPROT;
        end
        if (w_w_hs) begin
          w_w_got_n   = 1'b1;
          w_m_wdata_n = S_AXI_WDATA;
          w_m_wstrb_n = S_AXI_WSTRB;
        end
        if (w_aw_got_n && w_w_got_n) begin
          w_aw_got_n = 1'b0;
          w_w_got_n  = 1'b0;
          if (w_aw_hit_n) begin
            w_wstate_n    = W_ISSUE;
            w_m_awvalid_n = 1'b1;
            w_m_wvalid_n  = 1'b1;
          end else begin
            w_wstate_n   = W_DONE;
            w_s_bvalid_n = 1'b1;
            w_s_bresp_n  = RESP_DECERR;
          end
        end
      end
      W_ISSUE: begin
        if (r_m_awvalid && M_AXI_AWREADY) w_m_awvalid_n = 1'b0;
        if (r_m_wvalid && M_AXI_WREADY)   w_m_wvalid_n  = 1'b0;
        if (!w_m_awvalid_n && !w_m_wvalid_n) begin
          w_wstate_n   = W_RESP;
          w_m_bready_n = 1'b1;
        end
      end
      W_RESP: begin
        if (M_AXI_BVALID) begin
          w_m_bready_n = 1'b0;
          w_s_bvalid_n = 1'b1;
          w_s_bresp_n  = M_AXI_BRESP;
          w_wstate_n   = W_DONE;
        end
      end
      W_DONE: begin
        if (S_AXI_BREADY) begin
          w_s_bvalid_n = 1'b0;
          w_wstate_n   = W_IDLE;
        end
      end
      default: w_wstate_n = W_IDLE;
    endcase

    w_s_awready_n = (w_wstate_n == W_IDLE) && !w_aw_got_n;
    w_s_wready_n  = (w_wstate_n == W_IDLE) && !w_w_got_n;
  end

  // Write state and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate    <= W_IDLE;
      r_aw_got    <= 1'b0;
      r_w_got     <= 1'b0;
      r_aw_hit    <= 1'b0;
      r_s_awready <= 1'b0;
      r_s_wready  <= 1'b0;
      r_s_bvalid  <= 1'b0;
      r_s_bresp   <= '0;
      r_m_awvalid <= 1'b0;
      r_m_wvalid  <= 1'b0;
      r_m_bready  <= 1'b0;
      r_m_awaddr  <= '0;
      r_m_awprot  <= '0;
      r_m_wdata   <= '0;
      r_m_wstrb   <= '0;
    end else begin
      r_wstate    <= w_wstate_n;
      r_aw_got    <= w_aw_got_n;
      r_w_got     <= w_w_got_n;
      r_aw_hit    <= w_aw_hit_n;
      r_s_awready <= w_s_awready_n;
      r_s_wready  <= w_s_wready_n;
      r_s_bvalid  <= w_s_bvalid_n;
      r_s_bresp   <= w_s_bresp_n;
      r_m_awvalid <= w_m_awvalid_n;
      r_m_wvalid  <= w_m_wvalid_n;
      r_m_bready  <= w_m_bready_n;
      r_m_awaddr  <= w_m_awaddr_n;
      r_m_awprot  <= w_m_awprot_n;
      r_m_wdata   <= w_m_wdata_n;
      r_m_wstrb   <= w_m_wstrb_n;
    end
  end

  // --------------------------------------------------------------- read path
  r_state_t          r_rstate, w_rstate_n;
  logic              r_s_arready, w_s_arready_n, r_s_rvalid, w_s_rvalid_n;
  logic [DW-1:0]     r_s_rdata, w_s_rdata_n;
  logic [RESP_W-1:0] r_s_rresp, w_s_rresp_n;
  logic              r_m_arvalid, w_m_arvalid_n, r_m_rready, w_m_rready_n;
  logic [AW-1:0]     r_m_araddr, w_m_araddr_n;
  logic [PROT_W-1:0] r_m_arprot, w_m_arprot_n;
  logic              w_ar_hs;

  assign w_ar_hs = S_AXI_ARVALID && r_s_arready;

  // Read next-state and next-output logic
  always_comb begin
    w_rstate_n    = r_rstate;
    w_s_rvalid_n  = r_s_rvalid;
    w_s_rdata_n   = r_s_rdata;
    w_s_rresp_n   = r_s_rresp;
    w_m_arvalid_n = r_m_arvalid;
    w_m_rready_n  = r_m_rready;
    w_m_araddr_n  = r_m_araddr;
    w_m_arprot_n  = r_m_arprot;

    unique case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          if (w_ar_hit) begin
            w_rstate_n    = R_ISSUE;
            w_m_arvalid_n = 1'b1;
            w_m_araddr_n  = w_ar_xaddr;
            w_m_arprot_n  = S_AXI_ARPROT;
          end else begin
            w_rstate_n   = R_DONE;
            w_s_rvalid_n = 1'b1;
            w_s_rdata_n  = '0;
            w_s_rresp_n  = RESP_DECERR;
          end
        end
      end
      R_ISSUE: begin
        if (M_AXI_ARREADY) begin
          w_m_arvalid_n = 1'b0;
          w_m_rready_n  = 1'b1;
          w_rstate_n    = R_RESP;
        end
      end
      R_RESP: begin
        if (M_AXI_RVALID) begin
          w_m_rready_n = 1'b0;
          w_s_rvalid_n = 1'b1;
          w_s_rdata_n  = M_AXI_RDATA;
          w_s_rresp_n  = M_AXI_RRESP;
          w_rstate_n   = R_DONE;
        end
      end
      R_DONE: begin
        if (S_AXI_RREADY) begin
          w_s_rvalid_n = 1'b0;
          w_rstate_n   = R_IDLE;
        end
      end
      default: w_rstate_n = R_IDLE;
    endcase

    w_s_arready_n = (w_rstate_n == R_IDLE);
  end

  // Read state and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate    <= R_IDLE;
      r_s_arready <= 1'b0;
      r_s_rvalid  <= 1'b0;
      r_s_rdata   <= '0;
      r_s_rresp   <= '0;
      r_m_arvalid <= 1'b0;
      r_m_rready  <= 1'b0;
      r_m_araddr  <= '0;
      r_m_arprot  <= '0;
    end else begin
      r_rstate    <= w_rstate_n;
      r_s_arready <= w_s_arready_n;
      r_s_rvalid  <= w_s_rvalid_n;
      r_s_rdata   <= w_s_rdata_n;
      r_s_rresp   <= w_s_rresp_n;
      r_m_arvalid <= w_m_arvalid_n;
      r_m_rready  <= w_m_rready_n;
      r_m_araddr  <= w_m_araddr_n;
      r_m_arprot  <= w_m_arprot_n;
    end
  end

  // ------------------------------------------------------------ port drivers
  assign S_AXI_AWREADY = r_s_awready;
  assign S_AXI_WREADY  = r_s_wready;
  assign S_AXI_BVALID  = r_s_bvalid;
  assign S_AXI_BRESP   = r_s_bresp;
  assign S_AXI_ARREADY = r_s_arready;
  assign S_AXI_RVALID  = r_s_rvalid;
  assign S_AXI_RDATA   = r_s_rdata;
  assign S_AXI_RRESP   = r_s_rresp;

  assign M_AXI_AWVALID = r_m_awvalid;
  assign M_AXI_AWADDR  = r_m_awaddr;
  assign M_AXI_AWPROT  = r_m_awprot;
  assign M_AXI_WVALID  = r_m_wvalid;
  assign M_AXI_WDATA   = r_m_wdata;
  assign M_AXI_WSTRB   = r_m_wstrb;
  assign M_AXI_BREADY  = r_m_bready;
  assign M_AXI_ARVALID = r_m_arvalid;
  assign M_AXI_ARADDR  = r_m_araddr;
  assign M_AXI_ARPROT  = r_m_arprot;
  assign M_AXI_RREADY  = r_m_rready;

endmodule

// File: tb/tb_axi4_lite_window_remapper.sv
// Self-checking bench for axi4_lite_window_remapper. The bench plays both the
// upstream master and the downstream slave; expected addresses and responses
// come from a window table model.
module tb_axi4_lite_window_remapper;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [31:0] S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [31:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY = 1'b0;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY = 1'b0;
  logic [1:0]  M_AXI_BRESP = '0;
  logic        M_AXI_BVALID = 1'b0;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = '0;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi4_lite_window_remapper dut (
    .clk (clk), .resetn (resetn),
    .S_AXI_AWADDR (S_AXI_AWADDR), .S_AXI_AWPROT (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID), .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA (S_AXI_WDATA), .S_AXI_WSTRB (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID), .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP (S_AXI_BRESP), .S_AXI_BVALID (S_AXI_BVALID), .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR), .S_AXI_ARPROT (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID), .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA (S_AXI_RDATA), .S_AXI_RRESP (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID), .S_AXI_RREADY (S_AXI_RREADY),
    .M_AXI_AWADDR (M_AXI_AWADDR), .M_AXI_AWPROT (M_AXI_AWPROT),
    .M_AXI_AWVALID (M_AXI_AWVALID), .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA (M_AXI_WDATA), .M_AXI_WSTRB (M_AXI_WSTRB),
    .M_AXI_WVALID (M_AXI_WVALID), .M_AXI_WREADY (M_AXI_WREADY),
    .M_AXI_BRESP (M_AXI_BRESP), .M_AXI_BVALID (M_AXI_BVALID), .M_AXI_BREADY (M_AXI_BREADY),
    .M_AXI_ARADDR (M_AXI_ARADDR), .M_AXI_ARPROT (M_AXI_ARPROT),
    .M_AXI_ARVALID (M_AXI_ARVALID), .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA (M_AXI_RDATA), .M_AXI_RRESP (M_AXI_RRESP),
    .M_AXI_RVALID (M_AXI_RVALID), .M_AXI_RREADY (M_AXI_RREADY)
  );

  // Window table: 64 KiB windows, lowest index wins.
  localparam logic [31:0] LOC_BASE [2] = '{32'h4000_0000, 32'h5000_0000};
  localparam logic [31:0] REM_BASE [2] = '{32'h0000_0000, 32'h8000_0000};
  localparam logic [31:0] WIN_MASK = 32'h0000_FFFF;

  function automatic void model_xlate(input logic [31:0] a, output bit hit,
                                      output logic [31:0] xa);
    hit = 1'b0;
    xa  = '0;
    for (int i = 0; i < 2; i++) begin
      if (!hit && ((a & ~WIN_MASK) == (LOC_BASE[i] & ~WIN_MASK))) begin
        hit = 1'b1;
        xa  = (REM_BASE[i] & ~WIN_MASK) | (a & WIN_MASK);
      end
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0:       a = 32'h4000_0000;
      1:       a = 32'h5000_0000;
      2:       a = 32'h6000_0000;
      default: a = $urandom & ~WIN_MASK;
    endcase
    return a | ($urandom & WIN_MASK);
  endfunction

  // One full write as seen from both ports; optionally reset while waiting on B.
  task automatic wr_txn(input logic [31:0] addr, input logic [2:0] prot,
                        input logic [31:0] data, input logic [3:0] strb,
                        input int w_lead, input int aw_stall, input int b_stall,
                        input logic [1:0] sresp, input bit abort);
    bit hit; logic [31:0] xa; logic [1:0] exp_resp;
    bit aw_done, w_done; int t, aw_at, w_at;
    model_xlate(addr, hit, xa);
    aw_at = (w_lead > 0) ? w_lead : 0;
    w_at  = (w_lead < 0) ? -w_lead : 0;
    aw_done = 1'b0; w_done = 1'b0; t = 0;
    while (!(aw_done && w_done)) begin
      if (t > 50) begin
        n_tests++; n_fail++;
        $display("FAIL wr_accept_timeout: AWREADY=%b WREADY=%b required both accepted", S_AXI_AWREADY, S_AXI_WREADY);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        return;
      end
      S_AXI_AWADDR = addr; S_AXI_AWPROT = prot;
      S_AXI_WDATA = data;  S_AXI_WSTRB = strb;
      S_AXI_AWVALID = !aw_done && (t >= aw_at);
      S_AXI_WVALID  = !w_done && (t >= w_at);
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
      if (S_AXI_WVALID && S_AXI_WREADY)   w_done  = 1'b1;
      @(negedge clk); t++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;

    if (!hit) begin
      n_tests++;
      if (M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b0) begin
        n_fail++; $display("FAIL wr_miss_no_master: AWVALID=%b WVALID=%b required 0 0", M_AXI_AWVALID, M_AXI_WVALID);
      end
      n_tests++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b11) begin
        n_fail++; $display("FAIL wr_miss_resp: BVALID=%b BRESP=%b required 1 11", S_AXI_BVALID, S_AXI_BRESP);
      end
      exp_resp = 2'b11;
    end else begin
      n_tests++;
      if (M_AXI_AWVALID !== 1'b1 || M_AXI_WVALID !== 1'b1) begin
        n_fail++; $display("FAIL wr_issue_latency: AWVALID=%b WVALID=%b required 1 1", M_AXI_AWVALID, M_AXI_WVALID);
      end
      n_tests++;
      if (M_AXI_AWADDR !== xa || M_AXI_AWPROT !== prot) begin
        n_fail++; $display("FAIL wr_xlate: addr=%h prot=%h required %h %h", M_AXI_AWADDR, M_AXI_AWPROT, xa, prot);
      end
      n_tests++;
      if (M_AXI_WDATA !== data || M_AXI_WSTRB !== strb) begin
        n_fail++; $display("FAIL wr_data_fwd: data=%h strb=%h required %h %h", M_AXI_WDATA, M_AXI_WSTRB, data, strb);
      end
      M_AXI_WREADY = 1'b1;
      for (int i = 0; i < aw_stall; i++) begin
        @(negedge clk);
        M_AXI_WREADY = 1'b0;
        n_tests++;
        if (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== xa || M_AXI_WVALID !== 1'b0) begin
          n_fail++; $display("FAIL wr_aw_stall: AWVALID=%b addr=%h WVALID=%b required 1 %h 0", M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WVALID, xa);
        end
      end
      M_AXI_AWREADY = 1'b1;
      @(negedge clk);
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
      n_tests++;
      if (M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b0 || M_AXI_BREADY !== 1'b1) begin
        n_fail++; $display("FAIL wr_issue_done: AWVALID=%b WVALID=%b BREADY=%b required 0 0 1", M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY);
      end
      if (abort) begin
        resetn = 1'b0;
        #1;
        n_tests++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 6'b0) begin
          n_fail++; $display("FAIL abort_valids: AWV=%b WV=%b BRDY=%b BV=%b AWR=%b WR=%b required all 0",
                             M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
        end
        @(negedge clk); resetn = 1'b1;
        @(negedge clk);
        n_tests++;
        if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1 || S_AXI_BVALID !== 1'b0) begin
          n_fail++; $display("FAIL abort_idle: AWREADY=%b WREADY=%b BVALID=%b required 1 1 0", S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID);
        end
        return;
      end
      M_AXI_BVALID = 1'b1; M_AXI_BRESP = sresp;
      @(negedge clk);
      M_AXI_BVALID = 1'b0; M_AXI_BRESP = ~sresp;
      n_tests++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== sresp || M_AXI_BREADY !== 1'b0) begin
        n_fail++; $display("FAIL wr_b_latency: BVALID=%b BRESP=%b MBREADY=%b required 1 %b 0", S_AXI_BVALID, S_AXI_BRESP, M_AXI_BREADY, sresp);
      end
      exp_resp = sresp;
    end
    for (int i = 0; i < b_stall; i++) begin
      @(negedge clk);
      n_tests++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== exp_resp || M_AXI_AWVALID !== 1'b0) begin
        n_fail++; $display("FAIL wr_b_stall: BVALID=%b BRESP=%b MAWVALID=%b required 1 %b 0", S_AXI_BVALID, S_AXI_BRESP, M_AXI_AWVALID, exp_resp);
      end
    end
    S_AXI_BREADY = 1'b1;
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
    n_tests++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1) begin
      n_fail++; $display("FAIL wr_complete: BVALID=%b AWREADY=%b WREADY=%b required 0 1 1", S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
    end
  endtask

  // One full read as seen from both ports.
  task automatic rd_txn(input logic [31:0] addr, input logic [2:0] prot,
                        input int ar_stall, input int r_stall,
                        input logic [31:0] mdata, input logic [1:0] mresp);
    bit hit; logic [31:0] xa, exp_data; logic [1:0] exp_resp; int t;
    model_xlate(addr, hit, xa);
    S_AXI_ARADDR = addr; S_AXI_ARPROT = prot; S_AXI_ARVALID = 1'b1;
    t = 0;
    while (S_AXI_ARREADY !== 1'b1) begin
      if (t > 50) begin
        n_tests++; n_fail++;
        $display("FAIL rd_accept_timeout: ARREADY=%b required 1", S_AXI_ARREADY);
        S_AXI_ARVALID = 1'b0;
        return;
      end
      @(negedge clk); t++;
    end
    @(negedge clk);
    S_AXI_ARVALID = 1'b0;

    if (!hit) begin
      n_tests++;
      if (M_AXI_ARVALID !== 1'b0) begin
        n_fail++; $display("FAIL rd_miss_no_master: ARVALID=%b required 0", M_AXI_ARVALID);
      end
      n_tests++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h0 || S_AXI_RRESP !== 2'b11) begin
        n_fail++; $display("FAIL rd_miss_resp: RVALID=%b RDATA=%h RRESP=%b required 1 0 11", S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP);
      end
      exp_data = 32'h0; exp_resp = 2'b11;
    end else begin
      n_tests++;
      if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== xa || M_AXI_ARPROT !== prot) begin
        n_fail++; $display("FAIL rd_issue: ARVALID=%b addr=%h prot=%h required 1 %h %h", M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT, xa, prot);
      end
      for (int i = 0; i < ar_stall; i++) begin
        @(negedge clk);
        n_tests++;
        if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== xa) begin
          n_fail++; $display("FAIL rd_ar_stall: ARVALID=%b addr=%h required 1 %h", M_AXI_ARVALID, M_AXI_ARADDR, xa);
        end
      end
      M_AXI_ARREADY = 1'b1;
      @(negedge clk);
      M_AXI_ARREADY = 1'b0;
      n_tests++;
      if (M_AXI_ARVALID !== 1'b0 || M_AXI_RREADY !== 1'b1) begin
        n_fail++; $display("FAIL rd_ar_done: ARVALID=%b RREADY=%b required 0 1", M_AXI_ARVALID, M_AXI_RREADY);
      end
      M_AXI_RVALID = 1'b1; M_AXI_RDATA = mdata; M_AXI_RRESP = mresp;
      @(negedge clk);
      M_AXI_RVALID = 1'b0; M_AXI_RDATA = ~mdata; M_AXI_RRESP = ~mresp;
      n_tests++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== mdata || S_AXI_RRESP !== mresp || M_AXI_RREADY !== 1'b0) begin
        n_fail++; $display("FAIL rd_r_latency: RVALID=%b RDATA=%h RRESP=%b MRREADY=%b required 1 %h %b 0",
                           S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, M_AXI_RREADY, mdata, mresp);
      end
      exp_data = mdata; exp_resp = mresp;
    end
    for (int i = 0; i < r_stall; i++) begin
      @(negedge clk);
      n_tests++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp_data || S_AXI_RRESP !== exp_resp) begin
        n_fail++; $display("FAIL rd_r_stall: RVALID=%b RDATA=%h RRESP=%b required 1 %h %b", S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, exp_data, exp_resp);
      end
    end
    S_AXI_RREADY = 1'b1;
    @(negedge clk);
    S_AXI_RREADY = 1'b0;
    n_tests++;
    if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
      n_fail++; $display("FAIL rd_complete: RVALID=%b ARREADY=%b required 0 1", S_AXI_RVALID, S_AXI_ARREADY);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
         M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY} !== 10'b0) begin
      n_fail++; $display("FAIL reset_handshakes: AWR=%b WR=%b ARR=%b BV=%b RV=%b MAWV=%b MWV=%b MARV=%b MBR=%b MRR=%b required all 0",
                         S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
                         M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY);
    end
    n_tests++;
    if (M_AXI_AWADDR !== 32'h0 || M_AXI_ARADDR !== 32'h0 || S_AXI_RDATA !== 32'h0 || S_AXI_BRESP !== 2'b0) begin
      n_fail++; $display("FAIL reset_data: awaddr=%h araddr=%h rdata=%h bresp=%b required all 0",
                         M_AXI_AWADDR, M_AXI_ARADDR, S_AXI_RDATA, S_AXI_BRESP);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: AWR=%b WR=%b ARR=%b required 1 1 1", S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY);
    end
  endtask

  task automatic test_directed();
    wr_txn(32'h4000_1234, 3'b010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 1'b0);
    rd_txn(32'h5000_0010, 3'b001, 0, 0, 32'h1234_5678, 2'b00);
    rd_txn(32'h6000_0000, 3'b000, 0, 0, 32'hFFFF_FFFF, 2'b00);
    wr_txn(32'h6000_0004, 3'b000, 32'h0BAD_F00D, 4'h3, 0, 0, 0, 2'b00, 1'b0);
  endtask

  task automatic test_stall();
    wr_txn(32'h5000_ABCD, 3'b111, 32'hCAFE_0001, 4'hA, 3, 5, 4, 2'b10, 1'b0);
    rd_txn(32'h4000_FFFC, 3'b100, 3, 4, 32'h5555_AAAA, 2'b10);
  endtask

  task automatic test_reset_mid();
    wr_txn(32'h4000_0040, 3'b000, 32'h1111_2222, 4'hF, 0, 1, 0, 2'b00, 1'b1);
    wr_txn(32'h4000_0044, 3'b000, 32'h3333_4444, 4'hF, 0, 0, 0, 2'b00, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      wr_txn(rand_addr(), 3'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 4)) - 2,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2'($urandom), 1'b0);
      rd_txn(rand_addr(), 3'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom, 2'($urandom));
    end
  endtask

  task automatic test_concurrent();
    fork
      wr_txn(32'h4000_0100, 3'b001, 32'hA5A5_5A5A, 4'hC, 1, 2, 1, 2'b00, 1'b0);
      rd_txn(32'h5000_0200, 3'b010, 1, 2, 32'h0F0F_F0F0, 2'b00);
    join
    for (int n = 0; n < 8; n++) begin
      fork
        wr_txn(rand_addr(), 3'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 4)) - 2,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2'($urandom), 1'b0);
        rd_txn(rand_addr(), 3'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               $urandom, 2'($urandom));
      join
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    test_concurrent();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
